// File: rtl/store_commit_unit_pkg.sv
// Shared definitions for the store commit unit: FSM encoding, store width codes
// and the address field that selects the IO region.
package store_commit_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIDTH_SB  = 2'd0,
    WIDTH_SH  = 2'd1,
    WIDTH_SW  = 2'd2,
    WIDTH_RSV = 2'd3
  } width_t;

  localparam int IO_FIELD_LSB = 16;
  localparam int IO_FIELD_MSB = 17;

  // Index of the last byte written for a given store width; the reserved code behaves as SW.
  function automatic logic [1:0] last_byte_idx(input width_t width);
    case (width)
      WIDTH_SB: return 2'd0;
      WIDTH_SH: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/store_commit_unit_byte_sel.sv
// Byte-lane mux: picks byte idx of a little-endian 32-bit store word.
module store_byte_sel (
  input  logic [31:0] data,
  input  logic [1:0]  idx,
  output logic [7:0]  byte_out
);

  assign byte_out = data[{idx, 3'b000} +: 8];

endmodule

// File: rtl/store_commit_unit.sv
// Drains one committed store onto the shared byte-wide memory port, one byte per
// granted cycle, then pulses finish_store to release the ROB.
module store_commit_unit
  import store_commit_unit_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        commit_valid,
  input  logic [1:0]  commit_width,
  input  logic [31:0] commit_addr,
  input  logic [31:0] commit_data,
  output logic        mem_req,
  input  logic        mem_grant,
  input  logic        io_buffer_full,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic        finish_store,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_idx_q;
  logic [7:0]  lane_byte;
  logic        io_stall;
  logic        write_en;
  logic        accept;

  assign accept   = rdy_in && (state_q == ST_IDLE) && commit_valid;
  assign io_stall = (addr_q[IO_FIELD_MSB:IO_FIELD_LSB] == IO_ADDR_HI) && io_buffer_full;
  assign write_en = rdy_in && (state_q == ST_WRITE) && mem_grant && !io_stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // NOTE: the store latches are reset too, so a reset mid-store leaves nothing stale on the port.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else if (accept) begin
      addr_q     <= commit_addr;
      data_q     <= commit_data;
      idx_q      <= '0;
      last_idx_q <= last_byte_idx(width_t'(commit_width));
    end else if (write_en) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // NOTE: state_d is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit_valid) state_d = ST_REQ;
      ST_REQ:   if (mem_grant) state_d = ST_WRITE;
      ST_WRITE: begin
        // A dropped grant sends us back to arbitrate; idx is kept so the store resumes in place.
        if (!mem_grant) begin
          state_d = ST_REQ;
        end else if (!io_stall && (idx_q == last_idx_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  store_byte_sel u_byte_sel (
    .data     (data_q),
    .idx      (idx_q),
    .byte_out (lane_byte)
  );

  always_comb begin
    mem_req      = (state_q == ST_REQ) || (state_q == ST_WRITE);
    busy         = (state_q != ST_IDLE);
    mem_wr       = write_en;
    mem_a        = write_en ? (addr_q + {30'd0, idx_q}) : 32'd0;
    mem_dout     = write_en ? lane_byte : 8'd0;
    finish_store = rdy_in && (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_store_commit_unit.sv
// Directed and randomized checks of store_commit_unit against cycle tables and a
// byte-stream reference model.
module tb_store_commit_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        commit_valid;
  logic [1:0]  commit_width;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic        mem_req;
  logic        mem_grant;
  logic        io_buffer_full;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        finish_store;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  store_commit_unit dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .commit_valid   (commit_valid),
    .commit_width   (commit_width),
    .commit_addr    (commit_addr),
    .commit_data    (commit_data),
    .mem_req        (mem_req),
    .mem_grant      (mem_grant),
    .io_buffer_full (io_buffer_full),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .finish_store   (finish_store),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic req, input logic wr,
                             input logic [31:0] a, input logic [7:0] d,
                             input logic fin, input logic bsy);
    chk({tag, ".mem_req"},      {31'd0, mem_req},      {31'd0, req});
    chk({tag, ".mem_wr"},       {31'd0, mem_wr},       {31'd0, wr});
    chk({tag, ".mem_a"},        mem_a,                 a);
    chk({tag, ".mem_dout"},     {24'd0, mem_dout},     {24'd0, d});
    chk({tag, ".finish_store"}, {31'd0, finish_store}, {31'd0, fin});
    chk({tag, ".busy"},         {31'd0, busy},         {31'd0, bsy});
  endtask

  // Checks the current cycle's outputs, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic req, input logic wr,
                     input logic [31:0] a, input logic [7:0] d,
                     input logic fin, input logic bsy);
    @(negedge clk_in);
    chk_outputs(tag, req, wr, a, d, fin, bsy);
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_commit(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    commit_valid = 1'b1;
    commit_width = w;
    commit_addr  = a;
    commit_data  = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] word;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_width;
    int          r_count;
    int          r_got;
    bit          r_io;
    bit          r_done;

    rst_in = 1'b1; rdy_in = 1'b1; commit_valid = 1'b0; commit_width = '0;
    commit_addr = '0; commit_data = '0; mem_grant = 1'b0; io_buffer_full = 1'b0;
    #1;
    chk_outputs("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    cyc("idle", 0, 0, 0, 0, 0, 0);

    // SW, immediate grant: writes in cycles 2-5, finish in cycle 6
    word = 32'hDEADBEEF;
    mem_grant = 1'b1;
    drive_commit(2'd2, 32'h0000_1000, word);
    cyc("sw_c0", 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b0;
    cyc("sw_c1", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("sw_c%0d", i + 2), 1, 1, 32'h0000_1000 + 32'(i), word[8*i +: 8], 0, 1);
    cyc("sw_c6", 0, 0, 0, 0, 1, 1);
    mem_grant = 1'b0;
    cyc("sw_c7", 0, 0, 0, 0, 0, 0);

    // SB, grant arrives in cycle 4
    drive_commit(2'd0, 32'h0000_2003, 32'h1234_5678);
    cyc("sb_c0", 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b0;
    for (int i = 1; i <= 3; i++) cyc($sformatf("sb_c%0d", i), 1, 0, 0, 0, 0, 1);
    mem_grant = 1'b1;
    cyc("sb_c4", 1, 0, 0, 0, 0, 1);
    cyc("sb_c5", 1, 1, 32'h0000_2003, 8'h78, 0, 1);
    cyc("sb_c6", 0, 0, 0, 0, 1, 1);
    mem_grant = 1'b0;
    cyc("sb_c7", 0, 0, 0, 0, 0, 0);

    // SH to IO space with the sink full in cycles 2-4
    mem_grant = 1'b1;
    drive_commit(2'd1, 32'h0003_0000, 32'h0000_ABCD);
    cyc("io_c0", 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b0;
    cyc("io_c1", 1, 0, 0, 0, 0, 1);
    io_buffer_full = 1'b1;
    for (int i = 2; i <= 4; i++) cyc($sformatf("io_c%0d", i), 1, 0, 0, 0, 0, 1);
    io_buffer_full = 1'b0;
    cyc("io_c5", 1, 1, 32'h0003_0000, 8'hCD, 0, 1);
    cyc("io_c6", 1, 1, 32'h0003_0001, 8'hAB, 0, 1);
    cyc("io_c7", 0, 0, 0, 0, 1, 1);
    cyc("io_c8", 0, 0, 0, 0, 0, 0);

    // SW across the address wrap, rdy_in low in cycle 3
    drive_commit(2'd2, 32'hFFFF_FFFE, 32'h4433_2211);
    cyc("wrap_c0", 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b0;
    cyc("wrap_c1", 1, 0, 0, 0, 0, 1);
    cyc("wrap_c2", 1, 1, 32'hFFFF_FFFE, 8'h11, 0, 1);
    rdy_in = 1'b0;
    cyc("wrap_c3", 1, 0, 0, 0, 0, 1);
    rdy_in = 1'b1;
    cyc("wrap_c4", 1, 1, 32'hFFFF_FFFF, 8'h22, 0, 1);
    cyc("wrap_c5", 1, 1, 32'h0000_0000, 8'h33, 0, 1);
    cyc("wrap_c6", 1, 1, 32'h0000_0001, 8'h44, 0, 1);
    cyc("wrap_c7", 0, 0, 0, 0, 1, 1);
    cyc("wrap_c8", 0, 0, 0, 0, 0, 0);

    // finish_store held back while rdy_in is low in DONE
    drive_commit(2'd0, 32'h0000_0050, 32'h0000_00A5);
    cyc("pend_c0", 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b0;
    cyc("pend_c1", 1, 0, 0, 0, 0, 1);
    cyc("pend_c2", 1, 1, 32'h0000_0050, 8'hA5, 0, 1);
    rdy_in = 1'b0;
    cyc("pend_c3", 0, 0, 0, 0, 0, 1);
    cyc("pend_c4", 0, 0, 0, 0, 0, 1);
    rdy_in = 1'b1;
    cyc("pend_c5", 0, 0, 0, 0, 1, 1);
    cyc("pend_c6", 0, 0, 0, 0, 0, 0);

    // Second commit while busy is ignored; reset mid-WRITE aborts the store
    drive_commit(2'd2, 32'h0000_4000, 32'h1122_3344);
    cyc("abort_c0", 0, 0, 0, 0, 0, 0);
    drive_commit(2'd0, 32'h0000_9000, 32'hFFFF_FFFF);
    cyc("abort_c1", 1, 0, 0, 0, 0, 1);
    commit_valid = 1'b0;
    cyc("abort_c2", 1, 1, 32'h0000_4000, 8'h44, 0, 1);
    @(negedge clk_in);
    chk_outputs("abort_c3", 1, 1, 32'h0000_4001, 8'h33, 0, 1);
    rst_in = 1'b1;
    #1;
    chk_outputs("abort_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int i = 0; i < 6; i++) cyc($sformatf("abort_post%0d", i), 0, 0, 0, 0, 0, 0);
    mem_grant = 1'b0;

    // Randomized stores: every strobe must match the next byte the model expects
    for (int s = 0; s < 40; s++) begin
      r_width = 2'($urandom_range(0, 3));
      r_addr  = $urandom;
      if ($urandom_range(0, 2) == 0) r_addr[17:16] = 2'b11;
      r_data  = $urandom;
      r_count = (r_width == 2'd0) ? 1 : (r_width == 2'd1) ? 2 : 4;
      r_io    = (r_addr[17:16] == 2'b11);
      r_got   = 0;
      r_done  = 1'b0;

      rdy_in = 1'b1;
      mem_grant = ($urandom_range(0, 3) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      drive_commit(r_width, r_addr, r_data);
      @(negedge clk_in);
      chk($sformatf("rnd%0d.idle_busy", s), {31'd0, busy}, 32'd0);
      @(posedge clk_in); #1;

      for (int c = 0; c < 300 && !r_done; c++) begin
        rdy_in         = ($urandom_range(0, 4) != 0);
        mem_grant      = ($urandom_range(0, 3) != 0);
        io_buffer_full = ($urandom_range(0, 2) == 0);
        commit_valid   = ($urandom_range(0, 5) == 0);
        commit_width   = 2'($urandom_range(0, 3));
        commit_addr    = $urandom;
        commit_data    = $urandom;
        @(negedge clk_in);
        if (mem_wr) begin
          if (r_got < r_count) begin
            chk($sformatf("rnd%0d.addr%0d", s, r_got), mem_a, r_addr + 32'(r_got));
            chk($sformatf("rnd%0d.byte%0d", s, r_got), {24'd0, mem_dout}, {24'd0, r_data[8*r_got +: 8]});
          end else begin
            chk($sformatf("rnd%0d.extra_byte", s), 32'(r_got), 32'(r_count - 1));
          end
          chk($sformatf("rnd%0d.wr_gating", s), {29'd0, rdy_in, mem_grant, r_io && io_buffer_full}, 32'b110);
          r_got++;
        end else begin
          chk($sformatf("rnd%0d.idle_addr", s), mem_a, 32'd0);
        end
        if (finish_store) begin
          chk($sformatf("rnd%0d.fin_bytes", s), 32'(r_got), 32'(r_count));
          chk($sformatf("rnd%0d.fin_rdy", s), {31'd0, rdy_in}, 32'd1);
          r_done = 1'b1;
        end
        @(posedge clk_in); #1;
      end
      if (!r_done) chk($sformatf("rnd%0d.timeout", s), {31'd0, r_done}, 32'd1);
    end
    commit_valid = 1'b0;
    rdy_in = 1'b1;
    cyc("final_idle", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_commit_unit.md
STORE_COMMIT_UNIT -- requirements
Module: store_commit_unit

Interface
REQ-001 Parameter IO_ADDR_HI, default 2'b11; the store is an IO write when addr[17:16] equals this value.
REQ-002 clk_in  input  1  system clock; single clock domain.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global ready; low pauses the unit.
REQ-005 commit_valid  input  1  one-cycle pulse: ROB committed a store.
REQ-006 commit_width  input  2  store size: 0 = SB, 1 = SH, 2 = SW; 3 is reserved.
REQ-007 commit_addr  input  32  byte address of the store.
REQ-008 commit_data  input  32  store data, least significant byte first.
REQ-009 mem_req  output  1  request for the shared byte-wide memory port.
REQ-010 mem_grant  input  1  memory controller grants the port.
REQ-011 io_buffer_full  input  1  IO sink cannot accept a byte.
REQ-012 mem_a  output  32  memory byte address.
REQ-013 mem_dout  output  8  memory write byte.
REQ-014 mem_wr  output  1  write strobe; one byte is written per cycle when high.
REQ-015 finish_store  output  1  one-cycle pulse: store fully written; releases the ROB's is_storing.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, REQ, WRITE, DONE.
REQ-018 IDLE on commit_valid: latch addr, data and byte count; go to REQ.
  - Byte count: 1 for SB, 2 for SH, 4 for SW; width 3 is treated as SW.
  - Byte index idx resets to 0.
REQ-019 commit_valid outside IDLE shall be ignored, with no state change.
REQ-020 mem_req shall be 1 in REQ and WRITE, and 0 in IDLE and DONE.
REQ-021 REQ goes to WRITE in the cycle after mem_grant is sampled high; otherwise it stays in REQ.
REQ-022 Each WRITE cycle:
  - mem_wr = 1.
  - mem_a = latched addr + idx, modulo 2^32.
  - mem_dout = data[8*idx+7 : 8*idx].
  - idx increments.
REQ-023 WRITE goes to DONE after the byte with idx = count-1 is written.
REQ-024 For IO writes, while io_buffer_full = 1:
  - mem_wr = 0; idx, mem_a and mem_dout hold; the state is held.
REQ-025 DONE: finish_store = 1 for exactly one cycle, then go to IDLE.
REQ-026 Outputs outside a write strobe: mem_wr = 0, mem_a = 0, mem_dout = 0.
REQ-027 rdy_in = 0 freezes all state, forces mem_wr = 0 and finish_store = 0, and drops no byte.
REQ-028 A pending finish_store pulse is delivered when rdy_in returns high.
REQ-029 Latency for SW with immediate grant and no IO stall:
  - commit sampled at edge 0; REQ in cycle 1; WRITE in cycles 2-5; finish_store in cycle 6.
REQ-030 Minimum accept-to-accept interval shall be count + 3 cycles.
REQ-031 mem_grant shall be held by the controller while mem_req is high.
  - If grant drops in WRITE, the unit shall return to REQ with idx preserved and resume at that idx after re-grant.
REQ-032 ROB rollback shall not affect this unit, because committed stores are architectural.
REQ-033 An address carry across 0xFFFFFFFF shall wrap to 0x00000000.

Reset
REQ-034 rst_in high shall force, asynchronously, regardless of rdy_in:
  - State IDLE, idx 0, latches 0.
  - mem_req, mem_wr, finish_store and busy = 0; mem_a and mem_dout = 0.
REQ-035 Reset during WRITE shall abort the store with no finish_store pulse; remaining bytes shall not be written.

Structure
REQ-036 Constants go in the shared include with the existing operation-type defines:
  - Width codes and FSM state encodings.
  - IO address field position [17:16].
REQ-037 One sub-module is natural: store_byte_sel, combinational byte-lane mux (data, idx -> byte).
  - No other hierarchy.

Verification
REQ-038 SW: addr 0x1000, data 0xDEADBEEF, grant immediate.
  - -> writes EF@0x1000, BE@0x1001, AD@0x1002, DE@0x1003 in cycles 2-5.
  - -> finish_store in cycle 6 only.
REQ-039 SB: addr 0x2003, data 0x12345678, grant delayed 3 cycles.
  - -> mem_req high for cycles 1-4.
  - -> single write 0x78@0x2003 in cycle 5; finish_store in cycle 6.
REQ-040 SH IO: addr 0x30000, data 0xABCD, io_buffer_full high for cycles 2-4.
  - -> CD@0x30000 in cycle 5, AB@0x30001 in cycle 6, finish_store in cycle 7.
REQ-041 SW: addr 0xFFFFFFFE, rdy_in low in cycle 3.
  - -> writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, with one extra stalled cycle.
  - -> no duplicated or skipped byte.
REQ-042 Second commit_valid while busy, then rst_in asserted mid-WRITE.
  - -> second commit ignored.
  - -> all outputs 0 immediately on rst_in; no finish_store.
